// File: rtl/paddsub_seq.sv
// Sequential packed 4x4-bit signed add/subtract: one shared 4-bit adder walks
// lanes 0..3 in CALC, then holds the result in DONE until the consumer takes it.
module paddsub_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic [3:0]  ovf,
    output logic        error
);

    localparam int unsigned LANE_W = 4;
    localparam int unsigned LANES  = 4;
    localparam int unsigned DATA_W = LANE_W * LANES;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    lane_q, lane_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                sub_q, sub_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [LANES-1:0]    ovf_q, ovf_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;

    logic [LANE_W-1:0]   a_lane;
    logic [LANE_W-1:0]   b_lane;
    logic [LANE_W-1:0]   op_b;
    logic [LANE_W-1:0]   sum;
    logic                lane_ovf;

    // Shared lane adder; subtraction is a + ~b + 1, carry-out dropped.
    always_comb begin
        a_lane = '0;
        b_lane = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane_q == CNT_W'(i)) begin
                a_lane = a_q[i*LANE_W +: LANE_W];
                b_lane = b_q[i*LANE_W +: LANE_W];
            end
        end
        op_b     = sub_q ? ~b_lane : b_lane;
        sum      = a_lane + op_b + LANE_W'(sub_q);
        lane_ovf = (a_lane[LANE_W-1] == op_b[LANE_W-1]) &&
                   (sum[LANE_W-1] != a_lane[LANE_W-1]);
    end

    // Next-state and register updates.
    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        result_d = result_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    sub_d    = sub;
                    result_d = '0;
                    ovf_d    = '0;
                    lane_d   = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    if (lane_q == CNT_W'(i)) begin
                        result_d[i*LANE_W +: LANE_W] = sum;
                        ovf_d[i]                     = lane_ovf;
                    end
                end
                lane_d = lane_q + CNT_W'(1);
                if (lane_q == CNT_W'(LANES - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            result_q    <= '0;
            ovf_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign error     = |ovf_q;

endmodule

// File: tb/tb_paddsub_seq.sv
// Self-checking bench for paddsub_seq: vector table plus random vectors through
// a result scoreboard, with backpressure and mid-CALC reset sequences.
module tb_paddsub_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  ovf;
    logic        error;

    paddsub_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  ovf;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_fail;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: true signed lane arithmetic, overflow when out of 4-bit range.
    function automatic void model(input logic s, input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] r, output logic [3:0] o);
        int sx;
        int sy;
        int t;
        for (int i = 0; i < 4; i++) begin
            sx = int'($signed(x[i*4 +: 4]));
            sy = int'($signed(y[i*4 +: 4]));
            t  = s ? (sx - sy) : (sx + sy);
            r[i*4 +: 4] = 4'(t);
            o[i]        = (t > 7) || (t < -8);
        end
    endfunction

    task automatic run_txn(input logic s, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] er, input logic [3:0] eo, input int hold);
        int   n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        a        = x;
        b        = y;
        sub      = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        sb_q.push_back('{res: er, ovf: eo});
        n = 0;
        while (!out_valid && n < 20) begin
            check("in_ready_busy", 32'(in_ready), 32'd0);
            tick();
            n++;
        end
        check("latency", 32'(n), 32'd4);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
        end else begin
            e = sb_q.pop_front();
            check("result", 32'(result), 32'(e.res));
            check("ovf", 32'(ovf), 32'(e.ovf));
            check("error", 32'(error), 32'(|e.ovf));
            check("in_ready_done", 32'(in_ready), 32'd0);
            for (int k = 0; k < hold; k++) begin
                a        = 16'($urandom);
                b        = 16'($urandom);
                sub      = 1'($urandom);
                in_valid = 1'($urandom);
                tick();
                check("hold_out_valid", 32'(out_valid), 32'd1);
                check("hold_in_ready", 32'(in_ready), 32'd0);
                check("hold_result", 32'(result), 32'(e.res));
                check("hold_ovf", 32'(ovf), 32'(e.ovf));
                check("hold_error", 32'(error), 32'(|e.ovf));
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("post_out_valid", 32'(out_valid), 32'd0);
            check("post_in_ready", 32'(in_ready), 32'd1);
            check("post_result_kept", 32'(result), 32'(e.res));
            check("post_ovf_kept", 32'(ovf), 32'(e.ovf));
        end
    endtask

    initial begin
        vec_t        vecs[4];
        logic [15:0] rr;
        logic [3:0]  ro;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        int          n;

        vecs[0] = '{sub: 1'b0, a: 16'h5555, b: 16'h6666, res: 16'hBBBB, ovf: 4'b1111};
        vecs[1] = '{sub: 1'b1, a: 16'h5555, b: 16'h6666, res: 16'hFFFF, ovf: 4'b0000};
        vecs[2] = '{sub: 1'b0, a: 16'h1234, b: 16'h1111, res: 16'h2345, ovf: 4'b0000};
        vecs[3] = '{sub: 1'b1, a: 16'h8070, b: 16'h1010, res: 16'h7060, ovf: 4'b1000};

        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        tick();
        tick();
        check("rst_result", 32'(result), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            run_txn(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf, 0);
        end

        // Backpressure: three stalled DONE cycles with noisy inputs.
        run_txn(vecs[0].sub, vecs[0].a, vecs[0].b, vecs[0].res, vecs[0].ovf, 3);

        // Reset in the second CALC cycle discards the transaction.
        a        = 16'h5555;
        b        = 16'h6666;
        sub      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_result", 32'(result), 32'h0);
        check("midrst_ovf", 32'(ovf), 32'h0);
        check("midrst_error", 32'(error), 32'h0);
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_in_ready", 32'(in_ready), 32'h1);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid) n++;
        end
        check("midrst_no_output", 32'(n), 32'd0);
        run_txn(vecs[3].sub, vecs[3].a, vecs[3].b, vecs[3].res, vecs[3].ovf, 0);

        // Random vectors against the reference model.
        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            model(rs, ra, rb, rr, ro);
            run_txn(rs, ra, rb, rr, ro, int'($urandom_range(0, 2)));
        end

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/paddsub_seq.md
PADDSUB_SEQ -- requirements
Module: paddsub_seq

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset; synchronous and active-low.
REQ-003 SHALL have port: in_valid  input  1  operands a, b and sub are valid this cycle.
REQ-004 SHALL have port: in_ready  output  1  block can accept operands; high only in IDLE.
REQ-005 SHALL have port: a  input  16  four packed 4-bit signed lanes; lane i = a[4i+3:4i].
REQ-006 SHALL have port: b  input  16  four packed 4-bit signed lanes, same packing.
REQ-007 SHALL have port: sub  input  1  0 = lane-wise a+b, 1 = lane-wise a-b.
REQ-008 SHALL have port: out_valid  output  1  result, ovf and error are valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts the result this cycle.
REQ-010 SHALL have port: result  output  16  packed lane results, wrap-around (non-saturating).
REQ-011 SHALL have port: ovf  output  4  ovf[i] = signed overflow in lane i.
REQ-012 SHALL have port: error  output  1  OR of ovf[3:0].

Function
REQ-013 SHALL implement FSM states IDLE, CALC and DONE.
REQ-014 SHALL, in IDLE with in_valid=1, on that edge: register a, b and sub; clear result and ovf; set lane counter to 0; go to CALC.
REQ-015 SHALL ignore a, b and sub while in_ready=0; operand registers SHALL hold until the next accept.
REQ-016 SHALL use one 4-bit adder, processing one lane per CALC cycle in order lane 0,1,2,3, with the 2-bit lane counter incrementing per edge.
REQ-017 SHALL compute each lane independently, with no carry between lanes: add = a_i + b_i + 0; sub = a_i + ~b_i + 1.
REQ-018 SHALL discard each lane's carry-out; the 4-bit sum goes to result lane i.
REQ-019 SHALL set ovf[i]=1 iff both adder operands (a_i and b_i, or a_i and ~b_i) share sign bit 3 and the sum's bit 3 differs from it.
REQ-020 SHALL leave CALC for DONE on the edge that writes lane 3 (counter == 3).
REQ-021 SHALL drive out_valid=1 in DONE only.
REQ-022 SHALL take exactly 4 edges from the accept edge to the edge that enters DONE.
REQ-023 SHALL hold result, ovf and error stable while out_valid=1 and out_ready=0, for unlimited cycles.
REQ-024 SHALL, in DONE with out_ready=1, return to IDLE on that edge; out_valid SHALL deassert the next cycle.
REQ-025 SHALL keep result, ovf and error holding the last transaction after returning to IDLE, until the next accept.
REQ-026 SHALL NOT accept a new operand in the same cycle as a DONE handshake; the minimum transaction period is 6 cycles.
REQ-027 SHALL ignore out_ready outside DONE, and ignore in_valid outside IDLE.
REQ-028 SHALL drive error combinationally from the registered ovf, so error is consistent with ovf at all times.

Reset
REQ-029 SHALL, when rst_n=0 at a rising edge: state=IDLE, lane counter=0, result=16'h0000, ovf=4'b0000, error=0, out_valid=0, in_ready=1, operand registers=0.
REQ-030 SHALL apply reset from any state, including mid-CALC; the partial transaction is discarded and no out_valid is produced for it.
REQ-031 SHALL give rst_n priority over in_valid and out_ready on the same edge.

Verification
REQ-032 SHALL test: add, a=16'h5555, b=16'h6666 -> result=16'hBBBB, ovf=4'b1111, error=1; out_valid first high 4 edges after the accept edge.
REQ-033 SHALL test: sub, a=16'h5555, b=16'h6666 -> result=16'hFFFF, ovf=4'b0000, error=0.
REQ-034 SHALL test: add, a=16'h1234, b=16'h1111 -> result=16'h2345, ovf=0, error=0.
REQ-035 SHALL test: sub, a=16'h8070, b=16'h1010 -> result=16'h7060, ovf=4'b1000, error=1.
REQ-036 SHALL test backpressure: out_ready=0 for 3 cycles in DONE, while a, b and in_valid toggle -> result and flags unchanged, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-037 SHALL test reset mid-CALC: rst_n=0 in the 2nd CALC cycle -> next cycle result=0, ovf=0, out_valid=0, in_ready=1; a fresh transaction then completes correctly.
